// File: rtl/seq_step_ctrl.sv
// Step sequencer for the a -> b -> c -> d chain datapath.
// A one-hot FSM writes one register per cycle, with start/busy/done handshake and a hold stall.
module seq_step_ctrl #(
    parameter int              WIDTH      = 8,
    parameter logic [WIDTH-1:0] INIT_VAL  = WIDTH'(46),
    parameter logic [WIDTH-1:0] STEP      = WIDTH'(1),
    parameter bit              AUTO_START = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] init_val,
    input  logic             hold,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             busy,
    output logic             done
);

    typedef enum logic [5:0] {
        ST_IDLE = 6'b000001,
        ST_S0   = 6'b000010,
        ST_S1   = 6'b000100,
        ST_S2   = 6'b001000,
        ST_S3   = 6'b010000,
        ST_DONE = 6'b100000
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Sum truncates to WIDTH bits, so the carry out is dropped (modulo 2^WIDTH).
    function automatic logic [WIDTH-1:0] add_step(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v + STEP;
        return r;
    endfunction

    // Next-state and register-write selection; hold freezes every step state.
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    seed_d  = init_val;
                    state_d = ST_S0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_S0: begin
                if (!hold) begin
                    a_d     = seed_q;
                    state_d = ST_S1;
                end else begin
                    state_d = ST_S0;
                end
            end
            ST_S1: begin
                if (!hold) begin
                    b_d     = add_step(a_q);
                    state_d = ST_S2;
                end else begin
                    state_d = ST_S1;
                end
            end
            ST_S2: begin
                if (!hold) begin
                    c_d     = add_step(b_q);
                    state_d = ST_S3;
                end else begin
                    state_d = ST_S2;
                end
            end
            ST_S3: begin
                if (!hold) begin
                    d_d     = add_step(c_q);
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_S3;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_S0) || (state_d == ST_S1) ||
                 (state_d == ST_S2) || (state_d == ST_S3);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset aborts any run and optionally arms the auto run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= AUTO_START ? ST_S0 : ST_IDLE;
            seed_q  <= AUTO_START ? INIT_VAL : {WIDTH{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            c_q     <= {WIDTH{1'b0}};
            d_q     <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a    = a_q;
    assign b    = b_q;
    assign c    = c_q;
    assign d    = d_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Directed bench for seq_step_ctrl: one auto-start instance and one start-only instance.
module tb_seq_step_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, hold;
    logic [7:0] init_val;
    logic [7:0] a, b, c, d;
    logic       busy, done;

    logic       rst2, start2, hold2;
    logic [7:0] init2;
    logic [7:0] a2, b2, c2, d2;
    logic       busy2, done2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_step_ctrl #(.WIDTH(8), .INIT_VAL(8'd46), .STEP(8'd1), .AUTO_START(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .init_val(init_val), .hold(hold),
        .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done)
    );

    seq_step_ctrl #(.WIDTH(8), .INIT_VAL(8'd46), .STEP(8'd1), .AUTO_START(1'b0)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .init_val(init2), .hold(hold2),
        .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] ea, eb, ec, ed,
                           input logic eby, edn);
        chk({tag, ".a"}, a, ea);
        chk({tag, ".b"}, b, eb);
        chk({tag, ".c"}, c, ec);
        chk({tag, ".d"}, d, ed);
        chk({tag, ".busy"}, {7'd0, busy}, {7'd0, eby});
        chk({tag, ".done"}, {7'd0, done}, {7'd0, edn});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0; init_val = 8'd0;
        rst2 = 1'b1; start2 = 1'b0; hold2 = 1'b0; init2 = 8'd0;
        step();
        chk_all("reset", 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);

        // Auto-start run from INIT_VAL
        rst = 1'b0; rst2 = 1'b0;
        step(); chk_all("auto.e1", 8'd46, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0);
        step(); chk_all("auto.e2", 8'd46, 8'd47, 8'd0, 8'd0, 1'b1, 1'b0);
        step(); chk_all("auto.e3", 8'd46, 8'd47, 8'd48, 8'd0, 1'b1, 1'b0);
        step(); chk_all("auto.e4", 8'd46, 8'd47, 8'd48, 8'd49, 1'b0, 1'b1);
        step(); chk_all("auto.e5", 8'd46, 8'd47, 8'd48, 8'd49, 1'b0, 1'b0);
        step(); chk_all("auto.idle", 8'd46, 8'd47, 8'd48, 8'd49, 1'b0, 1'b0);
        chk("noauto.busy2", {7'd0, busy2}, 8'd0);
        chk("noauto.a2", a2, 8'd0);

        // Wrap-around of the 8-bit adder
        init_val = 8'd254; start = 1'b1;
        step(); start = 1'b0;
        chk_all("wrap.k", 8'd46, 8'd47, 8'd48, 8'd49, 1'b1, 1'b0);
        step(); chk_all("wrap.k1", 8'd254, 8'd47, 8'd48, 8'd49, 1'b1, 1'b0);
        step(); chk_all("wrap.k2", 8'd254, 8'd255, 8'd48, 8'd49, 1'b1, 1'b0);
        step(); chk_all("wrap.k3", 8'd254, 8'd255, 8'd0, 8'd49, 1'b1, 1'b0);
        step(); chk_all("wrap.k4", 8'd254, 8'd255, 8'd0, 8'd1, 1'b0, 1'b1);
        step(); chk_all("wrap.k5", 8'd254, 8'd255, 8'd0, 8'd1, 1'b0, 1'b0);

        // Two held cycles in S2 delay the c write by two edges
        init_val = 8'd100; start = 1'b1;
        step(); start = 1'b0;
        step(); chk_all("hold.k1", 8'd100, 8'd255, 8'd0, 8'd1, 1'b1, 1'b0);
        step(); chk_all("hold.k2", 8'd100, 8'd101, 8'd0, 8'd1, 1'b1, 1'b0);
        hold = 1'b1;
        step(); chk_all("hold.k3", 8'd100, 8'd101, 8'd0, 8'd1, 1'b1, 1'b0);
        step(); chk_all("hold.k4", 8'd100, 8'd101, 8'd0, 8'd1, 1'b1, 1'b0);
        hold = 1'b0;
        step(); chk_all("hold.k5", 8'd100, 8'd101, 8'd102, 8'd1, 1'b1, 1'b0);
        step(); chk_all("hold.k6", 8'd100, 8'd101, 8'd102, 8'd103, 1'b0, 1'b1);
        hold = 1'b1;
        step(); chk_all("hold.done_not_stretched", 8'd100, 8'd101, 8'd102, 8'd103, 1'b0, 1'b0);
        hold = 1'b0;

        // Start while busy and while in DONE are both ignored
        init_val = 8'd50; start = 1'b1;
        step(); start = 1'b0;
        step(); chk("busy.k1.a", a, 8'd50);
        init_val = 8'd7; start = 1'b1;
        step(); start = 1'b0;
        chk_all("busy.k2", 8'd50, 8'd51, 8'd102, 8'd103, 1'b1, 1'b0);
        step(); chk("busy.k3.c", c, 8'd52);
        step(); chk_all("busy.k4", 8'd50, 8'd51, 8'd52, 8'd53, 1'b0, 1'b1);
        start = 1'b1;
        step(); start = 1'b0;
        chk_all("busy.k5", 8'd50, 8'd51, 8'd52, 8'd53, 1'b0, 1'b0);
        step(); chk_all("busy.noqueue", 8'd50, 8'd51, 8'd52, 8'd53, 1'b0, 1'b0);

        // Reset in S2 aborts the run, then the auto run restarts
        init_val = 8'd60; start = 1'b1;
        step(); start = 1'b0;
        step(); chk("rstmid.k1.a", a, 8'd60);
        step(); chk("rstmid.k2.b", b, 8'd61);
        rst = 1'b1;
        step(); chk_all("rstmid.reset", 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step(); chk_all("rstmid.e1", 8'd46, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0);
        step(); chk_all("rstmid.e2", 8'd46, 8'd47, 8'd0, 8'd0, 1'b1, 1'b0);
        step(); chk_all("rstmid.e3", 8'd46, 8'd47, 8'd48, 8'd0, 1'b1, 1'b0);
        step(); chk_all("rstmid.e4", 8'd46, 8'd47, 8'd48, 8'd49, 1'b0, 1'b1);

        // Restart on the start-only instance shows mixed old/new values
        init2 = 8'd5; start2 = 1'b1;
        step(); start2 = 1'b0;
        chk("rs.first.busy2", {7'd0, busy2}, 8'd1);
        repeat (4) step();
        chk("rs.first.d2", d2, 8'd8);
        chk("rs.first.done2", {7'd0, done2}, 8'd1);
        step();
        init2 = 8'd10; start2 = 1'b1;
        step(); start2 = 1'b0;
        step();
        chk("rs.k1.a2", a2, 8'd10);
        chk("rs.k1.b2", b2, 8'd6);
        chk("rs.k1.d2", d2, 8'd8);
        step(); chk("rs.k2.b2", b2, 8'd11);
        step();
        chk("rs.k3.c2", c2, 8'd12);
        chk("rs.k3.d2", d2, 8'd8);
        step();
        chk("rs.k4.d2", d2, 8'd13);
        chk("rs.k4.done2", {7'd0, done2}, 8'd1);
        chk("rs.k4.busy2", {7'd0, busy2}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
